tdsp_bus_arbiter: RTL and testbench
===================================

TDSP_BUS_ARBITER -- requirements
Module: tdsp_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, max consecutive DMA-owned cycles while core is requesting.
REQ-002 SHALL have parameter STARVE_LIM, default 16, DMA wait cycles after which DMA beats core.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 core_req  input  1  core data-bus request.
REQ-006 core_gnt  output  1  core data-bus grant.
REQ-007 core_as, core_read, core_write  input  1 each  core bus strobes.
REQ-008 core_addr  input  8  core address.
REQ-009 core_wdata  input  16  core write data.
REQ-010 dma_req  input  1  DMA/host request.
REQ-011 dma_gnt  output  1  DMA grant.
REQ-012 dma_as, dma_read, dma_write  input  1 each  DMA bus strobes.
REQ-013 dma_addr  input  8  DMA address.
REQ-014 dma_wdata  input  16  DMA write data.
REQ-015 mem_as, mem_read, mem_write  output  1 each  shared memory strobes.
REQ-016 mem_addr  output  8  shared memory address.
REQ-017 mem_wdata  output  16  shared memory write data.
REQ-018 dma_preempt  output  1  DMA must release; hold expired with core waiting.

Function
REQ-019 States: IDLE, CORE, DMA, TURN; state, grants, counters all registered.
REQ-020 IDLE: core_req=1 and starve count < STARVE_LIM -> CORE; else dma_req=1 -> DMA; else stay IDLE.
REQ-021 Grant latency: grant asserts the cycle after state entry is decided, i.e. one clock after request sampled in IDLE.
REQ-022 core_gnt=1 only in CORE; dma_gnt=1 only in DMA; never both asserted.
REQ-023 CORE: core_req=0 -> TURN; no preemption of core.
REQ-024 DMA: dma_req=0 -> TURN; hold counter increments each DMA cycle, clears on DMA entry.
REQ-025 dma_preempt=1 while in DMA, core_req=1 and hold count >= MAX_HOLD; grant held until dma_req drops.
REQ-026 TURN: exactly one cycle, no grants, mem outputs zero; then IDLE rules applied same cycle (TURN->CORE/DMA/IDLE directly).
REQ-027 Starve counter: increments each cycle dma_req=1 and dma_gnt=0, saturates at STARVE_LIM, clears when DMA entered.
REQ-028 Simultaneous core_req and dma_req in IDLE/TURN: core wins unless starve count = STARVE_LIM.
REQ-029 Mux: mem_* = core_* in CORE, dma_* in DMA, all zero in IDLE/TURN; combinational from state.
REQ-030 Strobes of non-granted requester SHALL be ignored.
REQ-031 Request dropped in same cycle grant asserts: owner state still entered, exits to TURN next cycle.

Reset
REQ-032 reset=0 SHALL immediately force IDLE, core_gnt=0, dma_gnt=0, dma_preempt=0, mem_* = 0, counters = 0, regardless of clock.
REQ-033 Reset mid-ownership SHALL drop grant asynchronously; first grant after release needs core_req/dma_req sampled at a clk edge.

Verification
REQ-034 Reset release, core_req=1 at cycle 0 -> core_gnt=1 at cycle 1, mem_addr follows core_addr.
REQ-035 core_req and dma_req both rise in IDLE -> core_gnt=1; core_req drops -> one TURN cycle (all gnts 0) -> dma_gnt=1.
REQ-036 DMA owns bus, core_req rises, MAX_HOLD=8 -> dma_preempt=1 after 8 DMA cycles; dma_req drops -> TURN -> core_gnt=1.
REQ-037 dma_req held 16 cycles while core hogs, core releases and re-requests same cycle -> DMA granted after TURN.
REQ-038 reset=0 asserted mid-DMA, between clock edges -> dma_gnt and mem_* zero immediately; after reset=1 state IDLE.
REQ-039 Throughout all tests: core_gnt and dma_gnt never both 1; mem_* zero whenever no grant.

Source files
------------

// File: rtl/tdsp_bus_arbiter.sv
// Two-master arbiter for the shared TDSP data memory.
// The core has priority and is never preempted. The DMA/host port holds the
// bus until it drops its request. dma_preempt asks DMA to let go once it has
// held the bus for MAX_HOLD cycles while the core waits. A starvation counter
// lets DMA beat the core after STARVE_LIM cycles of unanswered requests.
// Every change of owner passes through one dead TURN cycle.
//
//   state | meaning
//   IDLE  | bus free, no grant, memory strobes parked at zero
//   CORE  | core owns the bus, mem_* driven from core_*
//   DMA   | DMA owns the bus, mem_* driven from dma_*
//   TURN  | one dead cycle after a release, no grant, mem_* zero
module tdsp_bus_arbiter #(
  parameter int MAX_HOLD   = 8,
  parameter int STARVE_LIM = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  output logic        core_gnt,
  input  logic        core_as,
  input  logic        core_read,
  input  logic        core_write,
  input  logic [7:0]  core_addr,
  input  logic [15:0] core_wdata,
  input  logic        dma_req,
  output logic        dma_gnt,
  input  logic        dma_as,
  input  logic        dma_read,
  input  logic        dma_write,
  input  logic [7:0]  dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        mem_as,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        dma_preempt
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CORE = 2'd1,
    S_DMA  = 2'd2,
    S_TURN = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [HW-1:0]   hold_cnt;
  logic [SW-1:0]   starve_cnt;
  logic            starved;
  logic            hold_expired;
  logic            dma_enter;

  assign starved      = (starve_cnt == SW'(STARVE_LIM));
  assign hold_expired = (hold_cnt >= HW'(MAX_HOLD));
  assign dma_enter    = (state_nxt == S_DMA) && (state != S_DMA);

  // Next-state decision. IDLE and TURN share the same arbitration rules.
  // A saturated starve count only beats the core while DMA is still asking;
  // if DMA has gone away the core is served so it cannot lock itself out.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_TURN: begin
        if (core_req && (!starved || !dma_req)) state_nxt = S_CORE;
        else if (dma_req)                       state_nxt = S_DMA;
        else                                    state_nxt = S_IDLE;
      end
      S_CORE:  if (!core_req) state_nxt = S_TURN;
      S_DMA:   if (!dma_req)  state_nxt = S_TURN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset parks the bus immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Hold counter: cycles spent in DMA since entry, saturating at MAX_HOLD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                hold_cnt <= '0;
    else if (dma_enter)                        hold_cnt <= '0;
    else if (state == S_DMA && !hold_expired)  hold_cnt <= hold_cnt + HW'(1);
  end

  // Starve counter: cycles DMA has asked without a grant, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             starve_cnt <= '0;
    else if (dma_enter)                     starve_cnt <= '0;
    else if (dma_req && !dma_gnt && !starved) starve_cnt <= starve_cnt + SW'(1);
  end

  // Grants and preempt request decoded from the registered state.
  assign core_gnt    = (state == S_CORE);
  assign dma_gnt     = (state == S_DMA);
  assign dma_preempt = (state == S_DMA) && core_req && hold_expired;

  // Memory mux: only the owner's strobes reach memory, zero otherwise.
  always_comb begin
    mem_as    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 16'h0000;
    case (state)
      S_CORE: begin
        mem_as    = core_as;
        mem_read  = core_read;
        mem_write = core_write;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
      S_DMA: begin
        mem_as    = dma_as;
        mem_read  = dma_read;
        mem_write = dma_write;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tdsp_bus_arbiter.sv
// Bench for tdsp_bus_arbiter: directed scenarios followed by random traffic,
// all compared against a behavioural ownership model.
module tb_tdsp_bus_arbiter;

  localparam int MAX_HOLD   = 8;
  localparam int STARVE_LIM = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_as, core_read, core_write;
  logic [7:0]  core_addr;
  logic [15:0] core_wdata;
  logic        dma_req, dma_as, dma_read, dma_write;
  logic [7:0]  dma_addr;
  logic [15:0] dma_wdata;
  logic        core_gnt, dma_gnt, dma_preempt;
  logic        mem_as, mem_read, mem_write;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: who owns the bus, cycles held (unbounded), cycles DMA waited.
  bit m_core, m_dma;
  int m_hold, m_starve;

  tdsp_bus_arbiter #(.MAX_HOLD(MAX_HOLD), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_gnt(core_gnt),
    .core_as(core_as), .core_read(core_read), .core_write(core_write),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .dma_req(dma_req), .dma_gnt(dma_gnt),
    .dma_as(dma_as), .dma_read(dma_read), .dma_write(dma_write),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .mem_as(mem_as), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .dma_preempt(dma_preempt)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_core = 0; m_dma = 0; m_hold = 0; m_starve = 0;
  endtask

  // One rising edge worth of arbitration, from the rules in plain terms.
  task automatic model_step();
    int st;
    st = m_starve;
    if (dma_req && !m_dma) st = m_starve + 1;
    if (m_core) begin
      if (!core_req) m_core = 0;
    end else if (m_dma) begin
      m_hold = m_hold + 1;
      if (!dma_req) m_dma = 0;
    end else begin
      if (core_req && (m_starve < STARVE_LIM || !dma_req)) m_core = 1;
      else if (dma_req) begin
        m_dma = 1; m_hold = 0; st = 0;
      end
    end
    m_starve = st;
  endtask

  task automatic check_all();
    logic [7:0]  e_addr;
    logic [15:0] e_wdata;
    logic        e_as, e_rd, e_wr;
    e_as = 0; e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0;
    if (m_core) begin
      e_as = core_as; e_rd = core_read; e_wr = core_write; e_addr = core_addr; e_wdata = core_wdata;
    end else if (m_dma) begin
      e_as = dma_as; e_rd = dma_read; e_wr = dma_write; e_addr = dma_addr; e_wdata = dma_wdata;
    end
    chk("core_gnt", 32'(core_gnt), 32'(m_core));
    chk("dma_gnt", 32'(dma_gnt), 32'(m_dma));
    chk("dma_preempt", 32'(dma_preempt), 32'(m_dma && core_req && (m_hold >= MAX_HOLD)));
    chk("gnt_exclusive", 32'(core_gnt & dma_gnt), 32'd0);
    chk("mem_strobes", {29'd0, mem_as, mem_read, mem_write}, {29'd0, e_as, e_rd, e_wr});
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_bus();
    core_as = 1'($urandom); core_read = 1'($urandom); core_write = 1'($urandom);
    core_addr = 8'($urandom); core_wdata = 16'($urandom);
    dma_as = 1'($urandom); dma_read = 1'($urandom); dma_write = 1'($urandom);
    dma_addr = 8'($urandom); dma_wdata = 16'($urandom);
  endtask

  initial begin
    reset = 1'b0;
    core_req = 0; dma_req = 0;
    rand_bus();
    model_reset();

    // Reset state with live strobes on both sides.
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;

    // Core request at first cycle after release is granted one clock later.
    core_req = 1; core_addr = 8'h5A;
    #1 chk("no_gnt_before_edge", 32'(core_gnt), 32'd0);
    cycle();
    chk("core_first_gnt", 32'(core_gnt), 32'd1);
    chk("mem_addr_core", 32'(mem_addr), 32'h5A);
    core_addr = 8'hC3;
    #1 chk("mem_addr_follows", 32'(mem_addr), 32'hC3);
    core_req = 0;
    cycle();
    cycle();

    // Both request together from IDLE: core first, TURN, then DMA.
    rand_bus();
    core_req = 1; dma_req = 1;
    cycle();
    chk("both_core_wins", 32'(core_gnt), 32'd1);
    core_req = 0;
    cycle();
    chk("turn_no_gnt", {30'd0, core_gnt, dma_gnt}, 32'd0);
    cycle();
    chk("dma_after_turn", 32'(dma_gnt), 32'd1);

    // DMA holds while core waits; preempt after MAX_HOLD DMA cycles.
    core_req = 1;
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      rand_bus();
      cycle();
    end
    chk("preempt_not_yet", 32'(dma_preempt), 32'd0);
    cycle();
    chk("preempt_set", 32'(dma_preempt), 32'd1);
    cycle();
    chk("grant_held_preempt", 32'(dma_gnt), 32'd1);
    dma_req = 0;
    cycle();
    chk("turn_after_dma", {30'd0, core_gnt, dma_gnt}, 32'd0);
    cycle();
    chk("core_after_preempt", 32'(core_gnt), 32'd1);

    // Core hogs while DMA waits out the starve limit.
    dma_req = 1;
    for (int i = 0; i < STARVE_LIM; i++) begin
      rand_bus();
      cycle();
    end
    core_req = 0;
    cycle();
    core_req = 1;
    cycle();
    chk("starved_dma_wins", {30'd0, core_gnt, dma_gnt}, 32'd1);

    // Asynchronous reset while DMA owns the bus.
    dma_as = 1; dma_addr = 8'hA5;
    model_step();
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(dma_gnt), 32'd0);
    chk("async_rst_addr", 32'(mem_addr), 32'd0);
    model_reset();
    check_all();
    @(negedge clk);
    core_req = 0; dma_req = 1;
    reset = 1'b1;
    #1 chk("no_gnt_without_edge", 32'(dma_gnt), 32'd0);
    dma_req = 0;
    cycle();
    chk("idle_after_reset", {30'd0, core_gnt, dma_gnt}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rand_bus();
      if ($urandom_range(0, 5) == 0) core_req = ~core_req;
      if ($urandom_range(0, 7) == 0) dma_req = ~dma_req;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
